// File: rtl/seq_divider_if.sv
// seq_divider_if: operand and result handshake bundle for seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement truncating division.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst_n,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREP, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a, b, a_abs, b_abs, rem, quo;
    logic [CNT_W-1:0] cnt;
    logic             dbz;
    logic [WIDTH:0]   trial;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q, neg_r;
    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;
    assign bus.quotient  = (neg_q && !dbz) ? -quo : quo;
    assign bus.remainder = (neg_r && !dbz) ? -rem : rem;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == PREP) begin
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
        end
    end
`else
    assign a_abs = a;
    assign b_abs = b;
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
`endif
    assign bus.in_ready    = state == IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.div_by_zero = dbz;
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, b_abs};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.in_valid ? PREP : IDLE;
            PREP:    state_n = BUSY;
            BUSY:    state_n = (cnt == CNT_W'(1)) ? DONE : BUSY;
            DONE:    state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    // A zero divisor loads its result in PREP and idles one BUSY cycle so it lands two cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a   <= '0;
            b   <= '0;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a   <= bus.dividend;
                    b   <= bus.divisor;
                    dbz <= 1'b0;
                end
                PREP: begin
                    cnt <= (b == '0) ? CNT_W'(1) : CNT_W'(WIDTH);
                    dbz <= b == '0;
                    quo <= (b == '0) ? '1 : a_abs;
                    rem <= (b == '0) ? a : '0;
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!dbz) begin
                        rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic reference.
module tb_seq_divider;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic keep_ready = 1'b0;
    always #5 clk = ~clk;
    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        else if (a == MIN_NEG && b == '1) begin
            q = MIN_NEG;
            r = '0;
        end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction
    // Call at a negedge with the divider idle; returns at a negedge after handoff.
    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        logic [W-1:0] q, r, q0, r0;
        logic z, stable;
        int k, lat;
        ref_div(a, b, q, r, z);
        lat = z ? 2 : W + 1;
        chk({tag, ".in_ready"}, W'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        @(negedge clk);
        k = 0;
        while (!bus.out_valid && k < lat + 10) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, k, lat);
        if (stall > 0) begin
            q0 = bus.quotient;
            r0 = bus.remainder;
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                bus.in_valid = 1'b1;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
                @(posedge clk);
                @(negedge clk);
                stable &= bus.out_valid && !bus.in_ready && bus.quotient === q0 && bus.remainder === r0;
            end
            bus.in_valid = 1'b0;
            chk({tag, ".stall_stable"}, W'(stable), 1);
        end
        chk({tag, ".quotient"}, bus.quotient, q);
        chk({tag, ".remainder"}, bus.remainder, r);
        chk({tag, ".div_by_zero"}, W'(bus.div_by_zero), W'(z));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = keep_ready;
        chk({tag, ".out_valid_fall"}, W'(bus.out_valid), 0);
        chk({tag, ".in_ready_back"}, W'(bus.in_ready), 1);
    endtask
    initial begin
        logic seen;
        logic [W-1:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", W'(bus.in_ready), 1);
        chk("rst.out_valid", W'(bus.out_valid), 0);
        chk("rst.quotient", bus.quotient, 0);
        chk("rst.remainder", bus.remainder, 0);
        chk("rst.div_by_zero", W'(bus.div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 100;
        bus.divisor  = 7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", W'(bus.out_valid), 0);
        chk("midrst.in_ready", W'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        chk("midrst.no_result", W'(seen), 0);
        run("basic", 100, 7, 0);
        run("dbz", 32'h1234_5678, 0, 0);
        run("lt", 5, 9, 0);
        run("div1", '1, 1, 0);
        run("ones", '1, '1, 0);
        run("stall", 1000, 3, 20);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run("sneg_num", 32'hFFFF_FFF9, 2, 0);
        run("sneg_den", 7, 32'hFFFF_FFFE, 0);
        run("sovf", MIN_NEG, '1, 0);
`endif
        keep_ready = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run("rand", ra, rb, 0);
        end
        keep_ready = 1'b0;
        bus.out_ready = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
